// File: rtl/time_keeper.sv
// Wall clock with 1 Hz prescaler, button setting with auto-repeat and a 12/24-hour BCD display.
// Optional alarm (ports alarm_hour/alarm_min/alarm_ack/alarm_out) is built when TIME_KEEPER_ALARM_EN is defined.
module time_keeper #(
   parameter int unsigned CLK_HZ        = 100000000,
   parameter int unsigned REPEAT_CYCLES = 50000000
) (
   input  logic       CLK100MHZ,
   input  logic       Reset,
   input  logic       buttonMin,
   input  logic       buttonHrs,
   input  logic       mode12,
`ifdef TIME_KEEPER_ALARM_EN
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   input  logic [0:0] alarm_ack,
   output logic [0:0] alarm_out,
`endif
   output logic [3:0] hours2,
   output logic [3:0] hours1,
   output logic [3:0] mins2,
   output logic [3:0] mins1,
   output logic [5:0] seconds,
   output logic       pm,
   output logic       sec_tick
);

   localparam int unsigned PW = $clog2(CLK_HZ);
   localparam int unsigned HW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [4:0]    hour_q, hour_d;
   logic [5:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   // "button was low last cycle"; cleared by reset so a held button is not an edge
   logic          min_low_q, min_low_d;
   logic          hrs_low_q, hrs_low_d;
   logic [HW-1:0] min_cnt_q, min_cnt_d;
   logic [HW-1:0] hrs_cnt_q, hrs_cnt_d;

   logic          min_edge, hrs_edge, min_rep, hrs_rep;
   logic          min_inc, hrs_inc, carry_min, carry_hr;
   logic [4:0]    hr_sum;
   logic [4:0]    disp_hr;

   assign sec_tick = (presc_q == PW'(CLK_HZ - 1));
   assign min_edge = buttonMin & min_low_q;
   assign hrs_edge = buttonHrs & hrs_low_q;

   // Hold counters: a non-zero count means the button has been held since a valid edge
   always_comb begin
      min_cnt_d = '0;
      min_rep   = 1'b0;
      hrs_cnt_d = '0;
      hrs_rep   = 1'b0;
      if (REPEAT_CYCLES > 0) begin
         if (buttonMin) begin
            if (min_edge) begin
               min_cnt_d = HW'(1);
            end else if (min_cnt_q != '0) begin
               if (min_cnt_q == HW'(REPEAT_CYCLES)) begin
                  min_rep   = 1'b1;
                  min_cnt_d = HW'(1);
               end else begin
                  min_cnt_d = min_cnt_q + HW'(1);
               end
            end
         end
         if (buttonHrs) begin
            if (hrs_edge) begin
               hrs_cnt_d = HW'(1);
            end else if (hrs_cnt_q != '0) begin
               if (hrs_cnt_q == HW'(REPEAT_CYCLES)) begin
                  hrs_rep   = 1'b1;
                  hrs_cnt_d = HW'(1);
               end else begin
                  hrs_cnt_d = hrs_cnt_q + HW'(1);
               end
            end
         end
      end
   end

   // Time-of-day next state; a minute press discards any same-cycle tick carry
   always_comb begin
      min_inc   = min_edge | min_rep;
      hrs_inc   = hrs_edge | hrs_rep;
      carry_min = sec_tick & ~min_inc & (sec_q == 6'd59);
      carry_hr  = carry_min & (min_q == 6'd59);
      min_low_d = ~buttonMin;
      hrs_low_d = ~buttonHrs;

      presc_d = presc_q + PW'(1);
      if (min_inc || sec_tick) presc_d = '0;

      sec_d = sec_q;
      if (min_inc)       sec_d = 6'd0;
      else if (sec_tick) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;

      min_d = min_q;
      if (min_inc || carry_min) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;

      hr_sum = hour_q + 5'(hrs_inc) + 5'(carry_hr);
      hour_d = (hr_sum >= 5'd24) ? hr_sum - 5'd24 : hr_sum;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (Reset) begin
         presc_q   <= '0;
         hour_q    <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         min_low_q <= 1'b0;
         hrs_low_q <= 1'b0;
         min_cnt_q <= '0;
         hrs_cnt_q <= '0;
      end else begin
         presc_q   <= presc_d;
         hour_q    <= hour_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         min_low_q <= min_low_d;
         hrs_low_q <= hrs_low_d;
         min_cnt_q <= min_cnt_d;
         hrs_cnt_q <= hrs_cnt_d;
      end
   end

`ifdef TIME_KEEPER_ALARM_EN
   logic       alarm_q, alarm_d;
   logic [5:0] acnt_q, acnt_d;

   // Alarm arms only on a tick carry landing on hh:mm:00; self-clears after 60 ticks
   always_comb begin
      alarm_d = alarm_q;
      acnt_d  = acnt_q;
      if (carry_min && (hour_d == alarm_hour) && (min_d == alarm_min)) begin
         alarm_d = 1'b1;
         acnt_d  = 6'd0;
      end else if (alarm_q) begin
         if (alarm_ack[0]) begin
            alarm_d = 1'b0;
         end else if (sec_tick) begin
            if (acnt_q == 6'd59) alarm_d = 1'b0;
            else                 acnt_d  = acnt_q + 6'd1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (Reset) begin
         alarm_q <= 1'b0;
         acnt_q  <= '0;
      end else begin
         alarm_q <= alarm_d;
         acnt_q  <= acnt_d;
      end
   end

   assign alarm_out = alarm_q;
`endif

   always_comb begin
      disp_hr = hour_q;
      if (mode12) begin
         if (hour_q == 5'd0)       disp_hr = 5'd12;
         else if (hour_q > 5'd12)  disp_hr = hour_q - 5'd12;
      end
   end

   assign hours2  = 4'(disp_hr / 5'd10);
   assign hours1  = 4'(disp_hr % 5'd10);
   assign mins2   = 4'(min_q / 6'd10);
   assign mins1   = 4'(min_q % 6'd10);
   assign seconds = sec_q;
   assign pm      = (hour_q >= 5'd12);

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: vector table, seconds-of-day reference model and scoreboard queue.
module tb_time_keeper;
   localparam int CLK_HZ = 4;
   localparam int REP    = 8;

   logic       clk = 1'b0;
   logic       rst, bmin, bhrs, m12;
   logic [3:0] hours2, hours1, mins2, mins1;
   logic [5:0] seconds;
   logic       pm, sec_tick;
`ifdef TIME_KEEPER_ALARM_EN
   logic [4:0] ah = 5'd7;
   logic [5:0] am = 6'd30;
   logic [0:0] ack;
   logic [0:0] aout;
`endif

   time_keeper #(.CLK_HZ(CLK_HZ), .REPEAT_CYCLES(REP)) dut (
      .CLK100MHZ(clk), .Reset(rst), .buttonMin(bmin), .buttonHrs(bhrs), .mode12(m12),
`ifdef TIME_KEEPER_ALARM_EN
      .alarm_hour(ah), .alarm_min(am), .alarm_ack(ack), .alarm_out(aout),
`endif
      .hours2(hours2), .hours1(hours1), .mins2(mins2), .mins1(mins1),
      .seconds(seconds), .pm(pm), .sec_tick(sec_tick));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] h2, h1, m2, m1;
      logic [5:0] sec;
      logic       pm, tick, alm;
   } exp_t;
   typedef struct {
      logic rst, bmin, bhrs, m12;
      exp_t e;
   } vec_t;

   exp_t sbq[$];
   int   n_cmp = 0, n_bad = 0;

   // reference model state
   int tod = 0, presc = 0, m_since = 0, h_since = 0, acnt = 0;
   bit m_low = 0, h_low = 0, m_act = 0, h_act = 0, alm = 0;

   function automatic exp_t model_out(bit mode);
      exp_t e;
      int h = tod / 3600, m = (tod / 60) % 60, s = tod % 60;
      int d = mode ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
      e.h2 = 4'(d / 10); e.h1 = 4'(d % 10);
      e.m2 = 4'(m / 10); e.m1 = 4'(m % 10);
      e.sec = 6'(s); e.pm = (h >= 12); e.tick = (presc == CLK_HZ - 1);
`ifdef TIME_KEEPER_ALARM_EN
      e.alm = alm;
`else
      e.alm = 1'b0;
`endif
      return e;
   endfunction

   task automatic model_step(bit r, bit bm, bit bh, bit a);
      int  h, m, s, t;
      bit  tick, me, he, mr, hr, minc, hinc, carry;
      if (r) begin
         tod = 0; presc = 0; m_low = 0; h_low = 0; m_act = 0; h_act = 0; alm = 0; acnt = 0;
      end else begin
         tick = (presc == CLK_HZ - 1);
         me = bm && m_low; he = bh && h_low; mr = 0; hr = 0; carry = 0;
         if (bm && m_act && !me) begin m_since++; mr = (REP > 0) && (m_since % REP == 0); end
         if (bh && h_act && !he) begin h_since++; hr = (REP > 0) && (h_since % REP == 0); end
         if (me) begin m_act = 1; m_since = 0; end
         if (he) begin h_act = 1; h_since = 0; end
         if (!bm) m_act = 0;
         if (!bh) h_act = 0;
         minc = me | mr; hinc = he | hr;
         h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
         if (minc) begin
            m = (m + 1) % 60; s = 0; presc = 0;
         end else if (tick) begin
            carry = (s == 59);
            t = (tod + 1) % 86400;
            h = t / 3600; m = (t / 60) % 60; s = t % 60; presc = 0;
         end else begin
            presc++;
         end
         if (hinc) h = (h + 1) % 24;
         tod = h * 3600 + m * 60 + s;
         if (carry && h == 7 && m == 30) begin
            alm = 1; acnt = 0;
         end else if (alm) begin
            if (a) alm = 0;
            else if (tick) begin
               if (acnt == 59) alm = 0; else acnt++;
            end
         end
         m_low = !bm; h_low = !bh;
      end
   endtask

   // one clock: drive, push expectation after the edge, return just past the checking edge
   task automatic cyc_x(bit r, bit bm, bit bh, bit mode, bit a, bit use_e, exp_t e);
      rst = r; bmin = bm; bhrs = bh; m12 = mode;
`ifdef TIME_KEEPER_ALARM_EN
      ack = a;
`endif
      @(posedge clk);
      model_step(r, bm, bh, a);
      if (use_e) sbq.push_back(e);
      else       sbq.push_back(model_out(mode));
      @(negedge clk);
      #1;
   endtask

   task automatic cyc(bit r, bit bm, bit bh, bit mode, bit a);
      cyc_x(r, bm, bh, mode, a, 1'b0, '0);
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e, g;
         e = sbq.pop_front();
         g = {hours2, hours1, mins2, mins1, seconds, pm, sec_tick, 1'b0};
`ifdef TIME_KEEPER_ALARM_EN
         g.alm = aout[0];
`endif
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL scoreboard @%0t: got %0d%0d:%0d%0d:%0d pm=%0b tick=%0b alm=%0b, expected %0d%0d:%0d%0d:%0d pm=%0b tick=%0b alm=%0b",
                     $time, g.h2, g.h1, g.m2, g.m1, g.sec, g.pm, g.tick, g.alm,
                     e.h2, e.h1, e.m2, e.m1, e.sec, e.pm, e.tick, e.alm);
         end
      end
   end

   task automatic chk(string nm, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic press_hrs(int n);
      for (int i = 0; i < n; i++) begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); end
   endtask

   task automatic press_min(int n);
      for (int i = 0; i < n; i++) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
   endtask

   task automatic set_time(int h, int m);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      press_hrs(h);
      press_min(m);
   endtask

   task automatic wait_until(int h, int m, int s, bit need_tick);
      int k = 0;
      while (!(tod == h * 3600 + m * 60 + s && (!need_tick || presc == CLK_HZ - 1)) && k < 400) begin
         cyc(0, 0, 0, 0, 0);
         k++;
      end
      if (k >= 400) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_until %0d:%0d:%0d: cycle budget expired", h, m, s);
      end
   endtask

   function automatic vec_t mkv(bit r, bit bm, bit bh, bit mode, int h2, int h1, int m2, int m1,
                                int sec, bit p, bit tk);
      vec_t v;
      v.rst = r; v.bmin = bm; v.bhrs = bh; v.m12 = mode;
      v.e = {4'(h2), 4'(h1), 4'(m2), 4'(m1), 6'(sec), p, tk, 1'b0};
      return v;
   endfunction

   initial begin
      vec_t tbl[20];
      bit   rb_m, rb_h, rm;
      tbl[0] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int j = 1; j <= 12; j++) tbl[j] = mkv(0, 0, 0, 0, 0, 0, 0, 0, j / 4, 0, (j % 4) == 3);
      tbl[13] = mkv(0, 0, 0, 1, 1, 2, 0, 0, 3, 0, 0);
      tbl[14] = mkv(0, 0, 1, 1, 0, 1, 0, 0, 3, 0, 0);
      tbl[15] = mkv(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      tbl[16] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      tbl[17] = mkv(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      tbl[18] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
      tbl[19] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);

      rst = 1; bmin = 0; bhrs = 0; m12 = 0;
`ifdef TIME_KEEPER_ALARM_EN
      ack = 0;
`endif
      @(negedge clk);
      for (int i = 0; i < 20; i++)
         cyc_x(tbl[i].rst, tbl[i].bmin, tbl[i].bhrs, tbl[i].m12, 1'b0, 1'b1, tbl[i].e);

      // midnight rollover clears pm
      set_time(23, 59);
      wait_until(23, 59, 59, 1);
      chk("pm_before_midnight", pm, 1);
      cyc(0, 0, 0, 0, 0);
      chk("midnight_digits", {hours2, hours1, mins2, mins1}, 0);
      chk("midnight_sec", seconds, 0);
      chk("midnight_pm", pm, 0);

      // minute press on the tick cycle wins, prescaler restarts
      set_time(10, 59);
      wait_until(10, 59, 59, 1);
      cyc(0, 1, 0, 0, 0);
      chk("minpress_on_tick_hrs", {hours2, hours1}, 8'h10);
      chk("minpress_on_tick_min", {mins2, mins1}, 0);
      chk("minpress_on_tick_sec", seconds, 0);
      cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      chk("presc_restart_tick", sec_tick, 1);

      // display mode only
      set_time(13, 0);
      cyc(0, 0, 0, 0, 0);
      chk("h13_24h", {hours2, hours1}, 8'h13);
      cyc(0, 0, 0, 1, 0);
      chk("h13_12h", {hours2, hours1}, 8'h01);
      chk("h13_12h_pm", pm, 1);

      // auto-repeat from hour 22: edge, +8, +16
      set_time(22, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
      chk("repeat_hours", {hours2, hours1}, 8'h01);
      cyc(0, 0, 0, 0, 0);

      // button held through reset release does nothing until re-pressed
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
      chk("held_thru_reset", mins1, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("repress_after_reset", mins1, 1);

      // hour press together with a tick-driven hour carry, then both buttons at once
      set_time(5, 59);
      wait_until(5, 59, 59, 1);
      cyc(0, 0, 1, 0, 0);
      chk("hour_plus_carry", {hours2, hours1}, 8'h07);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("both_buttons", {hours2, hours1, mins2, mins1}, 16'h0801);

`ifdef TIME_KEEPER_ALARM_EN
      set_time(7, 29);
      wait_until(7, 29, 59, 1);
      cyc(0, 0, 0, 0, 0);
      chk("alarm_rise", aout, 1);
      cyc(0, 0, 0, 0, 1);
      chk("alarm_ack", aout, 0);
      set_time(7, 29);
      press_min(1);
      chk("alarm_button_no_trigger", aout, 0);
`endif

      // random soak against the model
      rb_m = 0; rb_h = 0; rm = 0;
      set_time(23, 58);
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0) rb_m = ~rb_m;
         if ($urandom_range(0, 6) == 0) rb_h = ~rb_h;
         if ($urandom_range(0, 3) == 0) rm = ~rm;
         cyc($urandom_range(0, 499) == 0, rb_m, rb_h, rm, $urandom_range(0, 49) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock cycles per second (min 2).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 50000000, held-button auto-repeat period in cycles (0 = repeat disabled).
REQ-003 SHALL have port CLK100MHZ  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port buttonMin  input  1  debounced level, high while minute button held.
REQ-006 SHALL have port buttonHrs  input  1  debounced level, high while hour button held.
REQ-007 SHALL have port mode12  input  1  display mode; 1 = 12-hour, 0 = 24-hour.
REQ-008 SHALL have ports hours2, hours1, mins2, mins1  output  4 each  BCD display digits (tens/units).
REQ-009 SHALL have port seconds  output  6  binary seconds 0-59.
REQ-010 SHALL have port pm  output  1  high for internal hours 12-23, in either mode.
REQ-011 SHALL have port sec_tick  output  1  one-cycle pulse on each one-second prescaler terminal count.

Function
REQ-012 Prescaler SHALL count 0..CLK_HZ-1 and wrap; sec_tick SHALL be high exactly in the cycle the count equals CLK_HZ-1.
REQ-013 Internal time SHALL be binary hour 0-23, minute 0-59, second 0-59; each sec_tick advances second, 59->0 carries into minute, minute 59->0 carries into hour, hour 23->0 wraps.
REQ-014 Outputs SHALL be combinational from internal registers: zero-latency after the edge that updates them.
REQ-015 mode12=0: hours2:hours1 SHALL show 00-23. mode12=1: SHALL show 12 for hour 0 and 12, hour-12 for 13-23, otherwise hour; leading tens digit 0.
REQ-016 mode12 SHALL affect display only, never internal count; it may change on any cycle.
REQ-017 Rising edge of buttonMin (1 after 0 the previous cycle) SHALL add one minute mod 60 with no hour carry, and clear seconds and prescaler to 0 in the same cycle.
REQ-018 Rising edge of buttonHrs SHALL add one hour mod 24; minutes, seconds, prescaler unchanged.
REQ-019 If REPEAT_CYCLES>0, a button held continuously SHALL repeat its increment every REPEAT_CYCLES cycles after the edge; release SHALL restart its hold counter. Each button SHALL have an independent hold counter.
REQ-020 Minute increment and sec_tick in the same cycle: the button SHALL win, so seconds read 0 and the tick carry is discarded.
REQ-021 Hour increment and a tick-driven hour carry in the same cycle SHALL both apply (hour +2 mod 24).
REQ-022 Simultaneous minute and hour increments SHALL both apply.

Reset
REQ-023 Reset SHALL clear prescaler, hour, minute, second, edge-detect and hold counters to 0, sampled on the clock edge, overriding all other inputs that cycle.
REQ-024 After reset: digits 0,0,0,0 (mode12=0) or 1,2,0,0 (mode12=1); seconds=0; pm=0; sec_tick=0.
REQ-025 A button held through reset release SHALL NOT increment until released and pressed again.

Configuration
REQ-026 Macro TIME_KEEPER_ALARM_EN SHALL, when defined, add inputs alarm_hour[4:0] (binary 0-23), alarm_min[5:0] (binary 0-59), alarm_ack[0:0] and output alarm_out[0:0].
REQ-027 With the macro, alarm_out SHALL rise the cycle after a tick-driven carry (not a button) makes internal time alarm_hour:alarm_min:00. It SHALL stay high until alarm_ack is sampled high or 60 sec_ticks elapse, and Reset SHALL clear it.
REQ-028 Without the macro, the alarm ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 CLK_HZ=4, Reset 1 cycle then idle 12 cycles -> sec_tick on cycles 4, 8, 12 and seconds=3.
REQ-030 Force 23:59:59 via buttons/ticks, next sec_tick -> 00:00:00, pm 1->0.
REQ-031 buttonMin rising edge on the sec_tick cycle at 10:59:59 -> 10:00:00 and prescaler restarts from 0.
REQ-032 Hour 13, toggle mode12 0->1 -> hours2:hours1 changes 1,3 -> 0,1 and pm stays 1; hour 0 with mode12=1 -> 1,2.
REQ-033 REPEAT_CYCLES=8, buttonHrs held 20 cycles from hour 22 -> hours 23, 0, 1 (edge, +8, +16).
REQ-034 ALARM_EN, alarm 07:30, count through 07:29:59 -> alarm_out high the next cycle; alarm_ack pulse -> low; setting 07:30 by button -> no alarm.
